mem_cache_responder: RTL

- Responder side of the MEM-stage memory request interface: accepts read/write requests from the MEM stage and returns read data plus a hit indication.
- Direct-mapped, one-word-per-line, write-through, no-write-allocate data cache between the MEM stage and the backing main memory.
- Misses and all writes go to the backing memory through a request/ready handshake; the MEM stage is held off via req_ready.

---
 rtl/mem_cache_pkg.sv | 18 +
 rtl/mem_cache_array.sv | 47 ++++
 rtl/mem_cache_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_cache_pkg.sv
// rtl/mem_cache_pkg.sv - shared commands, FSM states and default widths for the MEM-stage cache responder
package mem_cache_pkg;

    localparam int ADDR_W_DEF  = 22;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 6;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_cache_array.sv
// rtl/mem_cache_array.sv - direct-mapped tag/data/valid storage with combinational lookup and synchronous write
module mem_cache_array #(
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INDEX_W-1:0]        rd_index_i,
    output logic                      rd_valid_o,
    output logic [ADDR_W-INDEX_W-1:0] rd_tag_o,
    output logic [DATA_W-1:0]         rd_data_o,
    input  logic                      wr_en_i,
    input  logic [INDEX_W-1:0]        wr_index_i,
    input  logic [ADDR_W-INDEX_W-1:0] wr_tag_i,
    input  logic [DATA_W-1:0]         wr_data_i
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Valid bits are the only state that must be cleared; a write always leaves the line valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data words carry no reset; they are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_mem[wr_index_i]  <= wr_tag_i;
            data_mem[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_mem[rd_index_i];
    assign rd_data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/mem_cache_responder.sv
// rtl/mem_cache_responder.sv - write-through, no-write-allocate direct-mapped cache answering MEM-stage requests
module mem_cache_responder
    import mem_cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] result,
    output logic              cache_hit,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              hit_q, hit_d;
    logic              cache_hit_q, cache_hit_d;

    logic              lk_valid;
    logic [TAG_W-1:0]  lk_tag;
    logic [DATA_W-1:0] lk_data;
    logic              lookup_hit;

    logic              arr_we;
    logic [INDEX_W-1:0] arr_index;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_wdata;

    mem_cache_array #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_index_i (addr[INDEX_W-1:0]),
        .rd_valid_o (lk_valid),
        .rd_tag_o   (lk_tag),
        .rd_data_o  (lk_data),
        .wr_en_i    (arr_we),
        .wr_index_i (arr_index),
        .wr_tag_i   (arr_tag),
        .wr_data_i  (arr_wdata)
    );

    // The lookup always follows the live request address; it only matters in the acceptance cycle.
    assign lookup_hit = lk_valid && (lk_tag == addr[ADDR_W-1:INDEX_W]);

    // Next-state logic: capture the request in IDLE, then wait on the backing memory or answer directly.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        hit_d       = hit_q;
        cache_hit_d = cache_hit_q;
        arr_we      = 1'b0;
        arr_index   = addr_q[INDEX_W-1:0];
        arr_tag     = addr_q[ADDR_W-1:INDEX_W];
        arr_wdata   = mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = addr;
                    wdata_d = wr_data;
                    hit_d   = lookup_hit;
                    if (cmd == CMD_WRITE) begin
                        // Write hits update the line immediately; misses never allocate.
                        arr_we    = lookup_hit;
                        arr_index = addr[INDEX_W-1:0];
                        arr_tag   = addr[ADDR_W-1:INDEX_W];
                        arr_wdata = wr_data;
                        state_d   = WRITE;
                    end else if (lookup_hit) begin
                        result_d    = lk_data;
                        cache_hit_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_rdy) begin
                    arr_we      = 1'b1;
                    result_d    = mem_rdata;
                    cache_hit_d = 1'b0;
                    state_d     = RESP;
                end
            end
            WRITE: begin
                if (mem_rdy) begin
                    cache_hit_d = hit_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            hit_q       <= 1'b0;
            cache_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            hit_q       <= hit_d;
            cache_hit_q <= cache_hit_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign mem_re     = (state_q == FILL);
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign result     = result_q;
    assign cache_hit  = cache_hit_q;

endmodule
